// File: rtl/dds_pkg.sv
// Shared definitions for the DDS blocks (dds_pulse and dds_sweep_ctrl).
package dds_pkg;

  localparam int DDS_ACC_W   = 32;
  localparam int DDS_DWELL_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DWELL,
    ST_STEP,
    ST_DOWN,
    ST_FINISH
  } sweep_state_t;

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Control/status bundle between a sweep requester and dds_sweep_ctrl.
interface dds_sweep_ctrl_if
  import dds_pkg::*;
#(
  parameter int ACC_W   = DDS_ACC_W,
  parameter int DWELL_W = DDS_DWELL_W
);

  logic               start;
  logic               abort;
  logic [ACC_W-1:0]   f_start;
  logic [ACC_W-1:0]   f_stop;
  logic [ACC_W-1:0]   f_step;
  logic [DWELL_W-1:0] dwell;
  logic [ACC_W-1:0]   phase_in;
  logic [ACC_W-1:0]   freq_ctrl_f;
  logic [ACC_W-1:0]   freq_ctrl_p;
  logic               busy;
  logic               step_stb;
  logic               done;

  modport master (
    output start, abort, f_start, f_stop, f_step, dwell, phase_in,
    input  freq_ctrl_f, freq_ctrl_p, busy, step_stb, done
  );

  modport slave (
    input  start, abort, f_start, f_stop, f_step, dwell, phase_in,
    output freq_ctrl_f, freq_ctrl_p, busy, step_stb, done
  );

endinterface

// File: rtl/dds_dwell_timer.sv
// Loadable down-counter: after a load of D, expire is high in the max(D,1)-th cycle.
module dds_dwell_timer #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [DWELL_W-1:0] dwell,
  output logic               expire
);

  logic [DWELL_W-1:0] r_cnt;

  // NOTE: clocked state is written with <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - DWELL_W'(1);
    end
  end

  assign expire = (r_cnt == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Stepped frequency-sweep sequencer feeding dds_pulse freq/phase words.
// Define DDS_SWEEP_BIDIR_EN to build the triangle (up then down) sweep.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int ACC_W   = DDS_ACC_W,
  parameter int DWELL_W = DDS_DWELL_W
) (
  input  logic            clk,
  input  logic            reset,
  dds_sweep_ctrl_if.slave bus
);

  sweep_state_t       r_state, w_state_nxt;
  logic [ACC_W-1:0]   r_freq_f, w_freq_f_nxt;
  logic [ACC_W-1:0]   r_freq_p, w_freq_p_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_step_stb, w_step_nxt;
  logic               r_done, w_done_nxt;
  logic [ACC_W-1:0]   r_f_stop, r_f_step;
  logic [DWELL_W-1:0] r_dwell, w_timer_dwell;
  logic               w_accept, w_load, w_expire, w_at_stop;
  logic [ACC_W:0]     w_up_sum;
  logic [ACC_W-1:0]   w_up_next;
`ifdef DDS_SWEEP_BIDIR_EN
  logic [ACC_W-1:0]   r_f_start, w_down_next;
  logic [ACC_W:0]     w_down_diff;
`endif

  assign w_accept      = (r_state == ST_IDLE) && bus.start && !bus.abort;
  assign w_timer_dwell = w_accept ? bus.dwell : r_dwell;
  assign w_at_stop     = (r_freq_f >= r_f_stop);

  // Extra bit catches carry out; a zero step jumps straight to the stop word.
  assign w_up_sum  = {1'b0, r_freq_f} + {1'b0, r_f_step};
  assign w_up_next = ((r_f_step == '0) || (w_up_sum > {1'b0, r_f_stop}))
                   ? r_f_stop : w_up_sum[ACC_W-1:0];

`ifdef DDS_SWEEP_BIDIR_EN
  assign w_down_diff = {1'b0, r_freq_f} - {1'b0, r_f_step};
  assign w_down_next = ((r_f_step == '0) || w_down_diff[ACC_W] ||
                        (w_down_diff[ACC_W-1:0] < r_f_start))
                     ? r_f_start : w_down_diff[ACC_W-1:0];
`endif

  dds_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (w_load),
    .dwell  (w_timer_dwell),
    .expire (w_expire)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    w_state_nxt  = r_state;
    w_freq_f_nxt = r_freq_f;
    w_freq_p_nxt = r_freq_p;
    w_busy_nxt   = r_busy;
    w_step_nxt   = 1'b0;
    w_done_nxt   = 1'b0;
    w_load       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt  = ST_DWELL;
          w_freq_f_nxt = bus.f_start;
          w_freq_p_nxt = bus.phase_in;
          w_busy_nxt   = 1'b1;
          w_step_nxt   = 1'b1;
          w_load       = 1'b1;
        end
      end
      ST_DWELL, ST_STEP: begin
        w_state_nxt = ST_DWELL;
        if (w_expire) begin
          if (!w_at_stop) begin
            w_state_nxt  = ST_STEP;
            w_freq_f_nxt = w_up_next;
            w_step_nxt   = 1'b1;
            w_load       = 1'b1;
`ifdef DDS_SWEEP_BIDIR_EN
          end else if (r_freq_f > r_f_start) begin
            w_state_nxt  = ST_DOWN;
            w_freq_f_nxt = w_down_next;
            w_step_nxt   = 1'b1;
            w_load       = 1'b1;
`endif
          end else begin
            w_state_nxt = ST_FINISH;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end
        end
      end
`ifdef DDS_SWEEP_BIDIR_EN
      ST_DOWN: begin
        if (w_expire) begin
          if (r_freq_f <= r_f_start) begin
            w_state_nxt = ST_FINISH;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_freq_f_nxt = w_down_next;
            w_step_nxt   = 1'b1;
            w_load       = 1'b1;
          end
        end
      end
`endif
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase

    // Abort overrides everything; output words simply hold.
    if ((r_state != ST_IDLE) && bus.abort) begin
      w_state_nxt  = ST_IDLE;
      w_freq_f_nxt = r_freq_f;
      w_busy_nxt   = 1'b0;
      w_step_nxt   = 1'b0;
      w_done_nxt   = 1'b0;
      w_load       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_freq_f   <= '0;
      r_freq_p   <= '0;
      r_busy     <= 1'b0;
      r_step_stb <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_freq_f   <= w_freq_f_nxt;
      r_freq_p   <= w_freq_p_nxt;
      r_busy     <= w_busy_nxt;
      r_step_stb <= w_step_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Shadow copies isolate a running sweep from input changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_f_stop  <= '0;
      r_f_step  <= '0;
      r_dwell   <= '0;
`ifdef DDS_SWEEP_BIDIR_EN
      r_f_start <= '0;
`endif
    end else if (w_accept) begin
      r_f_stop  <= bus.f_stop;
      r_f_step  <= bus.f_step;
      r_dwell   <= bus.dwell;
`ifdef DDS_SWEEP_BIDIR_EN
      r_f_start <= bus.f_start;
`endif
    end
  end

  assign bus.freq_ctrl_f = r_freq_f;
  assign bus.freq_ctrl_p = r_freq_p;
  assign bus.busy        = r_busy;
  assign bus.step_stb    = r_step_stb;
  assign bus.done        = r_done;

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep sequencer that sits directly upstream of `dds_pulse` and drives its `freq_ctrl_f` and `freq_ctrl_p` inputs. On a start request it steps the frequency control word linearly from a start value to a stop value. Each word is held for a programmable dwell time, so a single DDS can produce stepped chirps without software intervention. The phase word is latched at start and held static for the whole sweep.

## Interface
- `ACC_W`, 32, width of the frequency and phase words; must match the `dds_pulse` accumulator width.
- `DWELL_W`, 16, width of the dwell counter.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle sweep request; sampled only in IDLE.
- `abort`  in  1  terminates the sweep; wins over `start` when both are high.
- `f_start`  in  ACC_W  first frequency word.
- `f_stop`  in  ACC_W  final frequency word (inclusive).
- `f_step`  in  ACC_W  increment per step.
- `dwell`  in  DWELL_W  cycles each word is held; 0 is treated as 1.
- `phase_in`  in  ACC_W  phase word applied for the sweep.
- `freq_ctrl_f`  out  ACC_W  frequency word to `dds_pulse`.
- `freq_ctrl_p`  out  ACC_W  phase word to `dds_pulse`.
- `busy`  out  1  high while a sweep is in progress.
- `step_stb`  out  1  one-cycle pulse in every cycle in which `freq_ctrl_f` takes a new value.
- `done`  out  1  one-cycle pulse when a sweep completes normally.

## Operation
- Reset values: `freq_ctrl_f`=0, `freq_ctrl_p`=0, `busy`=0, `step_stb`=0, `done`=0, state IDLE.
- States: IDLE, DWELL, STEP, (DOWN, with the bidirectional build), FINISH.
- IDLE, `start`=1 and `abort`=0:
  - Latch `f_start`, `f_stop`, `f_step`, `dwell` and `phase_in` into shadow registers.
  - Load `freq_ctrl_f` with `f_start` and `freq_ctrl_p` with `phase_in`.
  - Go to DWELL.
- DWELL: count the latched dwell. On the last count, go to STEP, or to FINISH if the current word already equals the terminal value.
- STEP: compute next = current + `f_step` in ACC_W+1 bits.
  - If next > `f_stop` (including carry out), load `f_stop`.
  - Otherwise load next.
  - Return to DWELL.
- `f_step`=0: the first STEP jumps straight to `f_stop`.
- `f_start` >= `f_stop`: the sweep outputs `f_start` for one dwell, then finishes. There is no clamp to `f_stop` in this case.
- FINISH: assert `done` for one cycle, drop `busy`, return to IDLE.
- Output words hold their last value in IDLE.
- `abort` in any non-IDLE state: go to IDLE next cycle, drop `busy`, no `done`, output words hold.
- `start` while busy is ignored. Shadow registers isolate the sweep from input changes mid-sweep.

## Timing
- `start` sampled at edge N: at N+1 `freq_ctrl_f`=`f_start`, `busy`=1, `step_stb`=1.
- Every word is visible for exactly max(`dwell`,1) cycles. The STEP cycle counts as the first cycle of the new word, so there is no bubble between words.
- `done` and `busy` falling are concurrent, one cycle after the last dwell cycle of the terminal word.
- `abort` at edge M: `busy`=0 at M+1. A `start` at M+1 is accepted.
- `step_stb` is never asserted in IDLE or FINISH.

## Configuration
- `DDS_SWEEP_BIDIR_EN` defined:
  - After the dwell on `f_stop`, enter DOWN and step by −`f_step`, clamping at the latched `f_start`.
  - The terminal word is `f_start`, so the sweep is a triangle.
  - `f_start` itself is dwelt twice in total (once at the start, once as terminal).
- `DDS_SWEEP_BIDIR_EN` undefined: the DOWN state and the subtractor are absent and the sweep is a single up-ramp (sawtooth when restarted).

## Structure
- Shared package `dds_pkg`:
  - `DDS_ACC_W` default (32).
  - State enum `sweep_state_t`.
  - Shared by `dds_pulse` and this block.
- Sub-module `dds_dwell_timer`: loadable down-counter with `load`, `dwell` and `expire` signals. It is reused by the future burst/gate stage.

## Test plan
- Basic up-ramp:
  - Stimulus: `f_start`=858993, `f_stop`=4294967, `f_step`=858993, `dwell`=4, `start` at N.
  - Response: words 858993, 1717986, 2576979, 3435972, 4294965, 4294967, each held 4 cycles; 6 `step_stb` pulses; `done` at N+25.
- `dwell`=0, `f_start`=100, `f_stop`=300, `f_step`=100:
  - Response: words 100, 200, 300, one cycle each; `done` at N+4.
- Overflow clamp:
  - Stimulus: `f_start`=32'hFFFF_FF00, `f_stop`=32'hFFFF_FFFF, `f_step`=32'h200.
  - Response: second word 32'hFFFF_FFFF (no wrap to 32'h100).
- Abort and simultaneous events:
  - `abort` asserted during the 3rd word: `busy`=0 next cycle, no `done`, word held.
  - `start`+`abort` in the same cycle in IDLE: no sweep starts.
- Reset mid-sweep:
  - Async `reset` asserted between edges: all outputs 0 immediately.
  - After release, a new `start` runs the sweep with the new `phase_in`=32'd573741 appearing on `freq_ctrl_p` at N+1.
- Bidirectional build (`DDS_SWEEP_BIDIR_EN`):
  - Stimulus: `f_start`=100, `f_stop`=300, `f_step`=100, `dwell`=1.
  - Response: words 100, 200, 300, 200, 100; `done` at N+6.
